// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_cfg_pkg
//  Description : Shared sizing helpers for the configurable switch block, so
//                the configuration-chain planner and the tile RTL derive
//                identical select widths and chain lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_cfg_pkg;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of one mux select field.
    function automatic int sel_w(input int mux_size);
        return clog2(mux_size);
    endfunction

    // Length of the configuration chain: one select field per mux, with
    // NUM_MUX muxes in each of the two output directions.
    function automatic int cfg_bits(input int num_mux, input int mux_size);
        return 2 * num_mux * sel_w(mux_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cfg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sb_cfg_mux
//  Description : MUX_SIZE:1 routing mux. A select value at or above MUX_SIZE
//                (reachable only for non-power-of-2 sizes) drives 0.
//  Ports       : i_sel  - select field
//                i_din  - mux inputs, bit 0 = channel track, 1.. = grid pins
//                o_dout - selected input
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_cfg_mux #(
    parameter int MUX_SIZE = 4,
    parameter int SEL_W    = 2
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic [MUX_SIZE-1:0] i_din,
    output logic                o_dout
);

    localparam logic [SEL_W:0] c_SEL_LIMIT = (SEL_W + 1)'(MUX_SIZE);

    // Pad to the full select range so any select value indexes a real bit.
    logic [(2**SEL_W)-1:0] w_din_pad;

    always_comb begin
        w_din_pad                 = '0;
        w_din_pad[MUX_SIZE-1:0]   = i_din;
        o_dout                    = 1'b0;
        if ({1'b0, i_sel} < c_SEL_LIMIT) begin
            o_dout = w_din_pad[i_sel];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sb_cfg_param.sv
`default_nettype none
// ============================================================================
//  Module      : sb_cfg_param
//  Description : Parametrised double-buffered switch block for a left-edge
//                tile (right + bottom channels). Configuration shifts into a
//                shadow register and is copied to the live selects only on a
//                commit, so routing stays stable while reprogramming.
//  Ports       : prog_clk / prog_reset     - clock, sync active-high reset
//                ccff_head / ccff_en       - serial config in, shift enable
//                cfg_commit                - copy shadow to active selects
//                chanx_right_in / chany_bottom_in   - incoming channels
//                right_pin_in / bottom_pin_in       - grid pins to the muxes
//                chanx_right_out / chany_bottom_out - outgoing channels
//                ccff_tail                 - serial config out
//                cfg_ready                 - full configuration shifted in
//                cfg_err                   - sticky configuration error
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_cfg_param
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_W   = 9,
    parameter int MUX_SIZE = 4,
    parameter int NUM_MUX  = 2
) (
    input  logic                            prog_clk,
    input  logic                            prog_reset,
    input  logic                            ccff_head,
    input  logic                            ccff_en,
    input  logic                            cfg_commit,
    input  logic [CHAN_W-1:0]               chanx_right_in,
    input  logic [CHAN_W-1:0]               chany_bottom_in,
    input  logic [NUM_MUX*(MUX_SIZE-1)-1:0] right_pin_in,
    input  logic [NUM_MUX*(MUX_SIZE-1)-1:0] bottom_pin_in,
    output logic [CHAN_W-1:0]               chanx_right_out,
    output logic [CHAN_W-1:0]               chany_bottom_out,
    output logic                            ccff_tail,
    output logic                            cfg_ready,
    output logic                            cfg_err
);

    localparam int SEL_W    = sel_w(MUX_SIZE);
    localparam int CFG_BITS = cfg_bits(NUM_MUX, MUX_SIZE);
    localparam int CNT_W    = clog2(CFG_BITS + 1);
    localparam int PINS     = MUX_SIZE - 1;

    localparam logic [CNT_W-1:0] c_CNT_FULL  = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_W:0]   c_SEL_LIMIT = (SEL_W + 1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                w_full;
    logic                w_shadow_bad;

    assign w_full = (r_cnt == c_CNT_FULL);

    // Flags a shadow image containing any select that has no mux input.
    always_comb begin
        w_shadow_bad = 1'b0;
        for (int m = 0; m < 2 * NUM_MUX; m++) begin
            if ({1'b0, r_shadow[m*SEL_W +: SEL_W]} >= c_SEL_LIMIT) begin
                w_shadow_bad = 1'b1;
            end
        end
    end

    // Commit and shift may coincide: the commit sees pre-edge shadow and
    // count, and an accepted commit then restarts the count at the bit that
    // was shifted on the same edge.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (ccff_en) begin
                r_shadow <= {r_shadow[CFG_BITS-2:0], ccff_head};
            end
            if (cfg_commit && w_full) begin
                r_active <= r_shadow;
                r_cnt    <= ccff_en ? c_CNT_ONE : '0;
                if (w_shadow_bad) begin
                    r_err <= 1'b1;
                end
            end else begin
                if (cfg_commit) begin
                    r_err <= 1'b1;
                end
                if (ccff_en && !w_full) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign ccff_tail = r_shadow[CFG_BITS-1];
    assign cfg_ready = w_full;
    assign cfg_err   = r_err;

    // Muxed tracks: right mux i takes bottom-channel track CHAN_W-2-i on
    // select 0, its own grid pins otherwise; bottom muxes mirror this.
    for (genvar i = 0; i < NUM_MUX; i++) begin : g_mux
        logic [MUX_SIZE-1:0] w_right_din;
        logic [MUX_SIZE-1:0] w_bottom_din;

        assign w_right_din  = {right_pin_in[i*PINS +: PINS],
                               chany_bottom_in[CHAN_W-2-i]};
        assign w_bottom_din = {bottom_pin_in[i*PINS +: PINS],
                               chanx_right_in[CHAN_W-2-i]};

        sb_cfg_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_right_mux (
            .i_sel  (r_active[i*SEL_W +: SEL_W]),
            .i_din  (w_right_din),
            .o_dout (chanx_right_out[i])
        );

        sb_cfg_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_bottom_mux (
            .i_sel  (r_active[(NUM_MUX+i)*SEL_W +: SEL_W]),
            .i_din  (w_bottom_din),
            .o_dout (chany_bottom_out[i])
        );
    end

    // Unmuxed tracks turn the corner with index reversal.
    for (genvar k = NUM_MUX; k <= CHAN_W - 2; k++) begin : g_pass
        assign chany_bottom_out[k] = chanx_right_in[CHAN_W-2-k];
        assign chanx_right_out[k]  = chany_bottom_in[CHAN_W-2-k];
    end

    // Top track turns the corner without reversal.
    assign chany_bottom_out[CHAN_W-1] = chanx_right_in[CHAN_W-1];
    assign chanx_right_out[CHAN_W-1]  = chany_bottom_in[CHAN_W-1];

endmodule
`default_nettype wire
